// File: rtl/mole_button_decoder.sv
// Mole button front end: two-flop synchronizer, per-button debounce, press edge
// detection, hit/miss classification against the lit-mole mask and saturating tallies.
module mole_button_decoder #(
  parameter int NUM_MOLES       = 5,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_WIDTH       = 20
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_MOLES-1:0] moleButton,
  input  logic [NUM_MOLES-1:0] moleLED,
  input  logic                 enable,
  input  logic                 clearCounts,
  output logic [NUM_MOLES-1:0] pressedStable,
  output logic                 hitPulse,
  output logic [2:0]           hitIndex,
  output logic                 missPulse,
  output logic [7:0]           hitCount,
  output logic [7:0]           missCount
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [7:0]           TALLY_MAX = 8'hFF;

  // Synchronizer and debounce state
  logic [NUM_MOLES-1:0] sync1_q;
  logic [NUM_MOLES-1:0] sync2_q;
  logic [CNT_WIDTH-1:0] cnt_q [NUM_MOLES];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_MOLES];
  logic [NUM_MOLES-1:0] stable_q;
  logic [NUM_MOLES-1:0] stable_d;
  logic [NUM_MOLES-1:0] stable_dly_q;

  // Classification and tally state
  logic                 hit_q,   hit_d;
  logic                 miss_q,  miss_d;
  logic [2:0]           idx_q,   idx_d;
  logic [7:0]           hcnt_q,  hcnt_d;
  logic [7:0]           mcnt_q,  mcnt_d;

  logic [NUM_MOLES-1:0] press;
  logic [NUM_MOLES-1:0] hit_vec;
  logic [NUM_MOLES-1:0] miss_vec;

  // A level change is accepted only after CNT_MAX+1 consecutive disagreeing samples;
  // any agreeing sample in between restarts the count.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NUM_MOLES; i++) begin
      cnt_d[i] = CNT_ZERO;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_d[i] = sync2_q[i];
          cnt_d[i]    = CNT_ZERO;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  assign press    = stable_q & ~stable_dly_q;
  assign hit_vec  = press & moleLED;
  assign miss_vec = press & ~moleLED;

  always_comb begin
    hit_d  = enable & (|hit_vec);
    miss_d = enable & (|miss_vec);
    idx_d  = idx_q;
    // Scan from the top so the lowest hitting index wins.
    if (enable) begin
      for (int i = NUM_MOLES - 1; i >= 0; i--) begin
        if (hit_vec[i]) begin
          idx_d = 3'(i);
        end
      end
    end
  end

  always_comb begin
    hcnt_d = hcnt_q;
    mcnt_d = mcnt_q;
    if (clearCounts) begin
      hcnt_d = 8'd0;
      mcnt_d = 8'd0;
    end else begin
      if (hit_d && (hcnt_q != TALLY_MAX)) begin
        hcnt_d = hcnt_q + 8'd1;
      end
      if (miss_d && (mcnt_q != TALLY_MAX)) begin
        mcnt_d = mcnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      for (int i = 0; i < NUM_MOLES; i++) begin
        cnt_q[i] <= CNT_ZERO;
      end
      hit_q  <= 1'b0;
      miss_q <= 1'b0;
      idx_q  <= 3'd0;
      hcnt_q <= 8'd0;
      mcnt_q <= 8'd0;
    end else begin
      sync1_q      <= moleButton;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      for (int i = 0; i < NUM_MOLES; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      hit_q  <= hit_d;
      miss_q <= miss_d;
      idx_q  <= idx_d;
      hcnt_q <= hcnt_d;
      mcnt_q <= mcnt_d;
    end
  end

  assign pressedStable = stable_q;
  assign hitPulse      = hit_q;
  assign hitIndex      = idx_q;
  assign missPulse     = miss_q;
  assign hitCount      = hcnt_q;
  assign missCount     = mcnt_q;

endmodule

// File: tb/tb_mole_button_decoder.sv
// Directed bench for mole_button_decoder with a short debounce period.
module tb_mole_button_decoder;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] moleButton;
  logic [4:0] moleLED;
  logic       enable;
  logic       clearCounts;
  logic [4:0] pressedStable;
  logic       hitPulse;
  logic [2:0] hitIndex;
  logic       missPulse;
  logic [7:0] hitCount;
  logic [7:0] missCount;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [4:0] btn;
    logic [4:0] led;
    logic       en;
    logic       clr;
    logic [4:0] es;
    logic       eh;
    logic [2:0] ei;
    logic       em;
    logic [7:0] ehc;
    logic [7:0] emc;
  } vec_t;

  vec_t tbl [10];

  mole_button_decoder #(
    .NUM_MOLES(5),
    .DEBOUNCE_CYCLES(4),
    .CNT_WIDTH(20)
  ) dut (
    .clock(clock),
    .reset(reset),
    .moleButton(moleButton),
    .moleLED(moleLED),
    .enable(enable),
    .clearCounts(clearCounts),
    .pressedStable(pressedStable),
    .hitPulse(hitPulse),
    .hitIndex(hitIndex),
    .missPulse(missPulse),
    .hitCount(hitCount),
    .missCount(missCount)
  );

  always #5 clock = ~clock;

  // Drive one set of inputs for n cycles; outputs are then sampled 1 ns after the edge.
  task automatic run(input logic [4:0] b, input logic [4:0] l, input logic en,
                     input logic clr, input int n);
    repeat (n) begin
      moleButton  = b;
      moleLED     = l;
      enable      = en;
      clearCounts = clr;
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [4:0] es, input logic eh,
                     input logic [2:0] ei, input logic em, input logic [7:0] ehc,
                     input logic [7:0] emc);
    logic [25:0] act;
    logic [25:0] exp;
    act = {pressedStable, hitPulse, hitIndex, missPulse, hitCount, missCount};
    exp = {es, eh, ei, em, ehc, emc};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got stable=%b hit=%b idx=%0d miss=%b hc=%0d mc=%0d, want stable=%b hit=%b idx=%0d miss=%b hc=%0d mc=%0d",
               name, pressedStable, hitPulse, hitIndex, missPulse, hitCount, missCount,
               es, eh, ei, em, ehc, emc);
    end
  endtask

  initial begin
    // Clean press on lit mole 2; row r holds the expectation after edge r+1.
    tbl[0] = '{5'b00100, 5'b00100, 1'b1, 1'b0, 5'b00000, 1'b0, 3'd0, 1'b0, 8'd0, 8'd0};
    tbl[1] = '{5'b00100, 5'b00100, 1'b1, 1'b0, 5'b00000, 1'b0, 3'd0, 1'b0, 8'd0, 8'd0};
    tbl[2] = '{5'b00100, 5'b00100, 1'b1, 1'b0, 5'b00000, 1'b0, 3'd0, 1'b0, 8'd0, 8'd0};
    tbl[3] = '{5'b00100, 5'b00100, 1'b1, 1'b0, 5'b00000, 1'b0, 3'd0, 1'b0, 8'd0, 8'd0};
    tbl[4] = '{5'b00100, 5'b00100, 1'b1, 1'b0, 5'b00000, 1'b0, 3'd0, 1'b0, 8'd0, 8'd0};
    tbl[5] = '{5'b00100, 5'b00100, 1'b1, 1'b0, 5'b00100, 1'b0, 3'd0, 1'b0, 8'd0, 8'd0};
    tbl[6] = '{5'b00100, 5'b00100, 1'b1, 1'b0, 5'b00100, 1'b1, 3'd2, 1'b0, 8'd1, 8'd0};
    tbl[7] = '{5'b00100, 5'b00100, 1'b1, 1'b0, 5'b00100, 1'b0, 3'd2, 1'b0, 8'd1, 8'd0};
    tbl[8] = '{5'b00100, 5'b00100, 1'b1, 1'b0, 5'b00100, 1'b0, 3'd2, 1'b0, 8'd1, 8'd0};
    tbl[9] = '{5'b00100, 5'b00100, 1'b1, 1'b0, 5'b00100, 1'b0, 3'd2, 1'b0, 8'd1, 8'd0};

    // Reset with random inputs, then idle.
    reset = 1'b1;
    moleButton = '0; moleLED = '0; enable = 1'b0; clearCounts = 1'b0;
    repeat (3) begin
      moleButton  = 5'($urandom_range(0, 31));
      moleLED     = 5'($urandom_range(0, 31));
      enable      = 1'($urandom_range(0, 1));
      clearCounts = 1'($urandom_range(0, 1));
      @(posedge clock);
      #1;
    end
    chk("reset", 5'b0, 1'b0, 3'd0, 1'b0, 8'd0, 8'd0);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      run(5'b0, 5'b0, 1'b1, 1'b0, 1);
      chk("idle", 5'b0, 1'b0, 3'd0, 1'b0, 8'd0, 8'd0);
    end

    for (int r = 0; r < 10; r++) begin
      run(tbl[r].btn, tbl[r].led, tbl[r].en, tbl[r].clr, 1);
      chk($sformatf("clean_press_row%0d", r), tbl[r].es, tbl[r].eh, tbl[r].ei,
          tbl[r].em, tbl[r].ehc, tbl[r].emc);
    end

    // Release produces no event.
    run(5'b0, 5'b00100, 1'b1, 1'b0, 8);
    chk("release", 5'b0, 1'b0, 3'd2, 1'b0, 8'd1, 8'd0);

    // Bounce on button 3 never reaches the debounce threshold.
    run(5'b01000, 5'b0, 1'b1, 1'b0, 3);
    chk("bounce_a", 5'b0, 1'b0, 3'd2, 1'b0, 8'd1, 8'd0);
    run(5'b00000, 5'b0, 1'b1, 1'b0, 2);
    chk("bounce_b", 5'b0, 1'b0, 3'd2, 1'b0, 8'd1, 8'd0);
    run(5'b01000, 5'b0, 1'b1, 1'b0, 2);
    chk("bounce_c", 5'b0, 1'b0, 3'd2, 1'b0, 8'd1, 8'd0);
    for (int k = 0; k < 8; k++) begin
      run(5'b00000, 5'b0, 1'b1, 1'b0, 1);
      chk("bounce_tail", 5'b0, 1'b0, 3'd2, 1'b0, 8'd1, 8'd0);
    end

    // Miss on unlit mole 0.
    run(5'b00001, 5'b00010, 1'b1, 1'b0, 6);
    chk("miss_pre", 5'b00001, 1'b0, 3'd2, 1'b0, 8'd1, 8'd0);
    run(5'b00001, 5'b00010, 1'b1, 1'b0, 1);
    chk("miss_pulse", 5'b00001, 1'b0, 3'd2, 1'b1, 8'd1, 8'd1);
    run(5'b00001, 5'b00010, 1'b1, 1'b0, 1);
    chk("miss_one_cycle", 5'b00001, 1'b0, 3'd2, 1'b0, 8'd1, 8'd1);
    run(5'b00000, 5'b00010, 1'b1, 1'b0, 8);
    chk("miss_release", 5'b0, 1'b0, 3'd2, 1'b0, 8'd1, 8'd1);

    // Simultaneous presses 1,3,4 with LEDs 1,3 lit: one hit and one miss.
    run(5'b11010, 5'b01010, 1'b1, 1'b0, 7);
    chk("multi_pulse", 5'b11010, 1'b1, 3'd1, 1'b1, 8'd2, 8'd2);
    run(5'b11010, 5'b01010, 1'b1, 1'b0, 1);
    chk("multi_after", 5'b11010, 1'b0, 3'd1, 1'b0, 8'd2, 8'd2);
    run(5'b00000, 5'b01010, 1'b1, 1'b0, 8);

    // Drive hitCount up to saturation.
    for (int k = 0; k < 253; k++) begin
      run(5'b00100, 5'b00100, 1'b1, 1'b0, 7);
      run(5'b00000, 5'b00100, 1'b1, 1'b0, 8);
    end
    chk("hit_255", 5'b0, 1'b0, 3'd2, 1'b0, 8'd255, 8'd2);
    run(5'b00100, 5'b00100, 1'b1, 1'b0, 7);
    chk("hit_saturate", 5'b00100, 1'b1, 3'd2, 1'b0, 8'd255, 8'd2);
    run(5'b00000, 5'b00100, 1'b1, 1'b0, 8);

    // Clear in the same cycle a hit is registered: counts clear, pulse still emitted.
    run(5'b00100, 5'b00100, 1'b1, 1'b0, 6);
    run(5'b00100, 5'b00100, 1'b1, 1'b1, 1);
    chk("clear_with_hit", 5'b00100, 1'b1, 3'd2, 1'b0, 8'd0, 8'd0);
    run(5'b00100, 5'b00100, 1'b1, 1'b0, 1);
    chk("clear_after", 5'b00100, 1'b0, 3'd2, 1'b0, 8'd0, 8'd0);
    run(5'b00000, 5'b00100, 1'b1, 1'b0, 8);

    // Disabled: debounce runs, no events.
    for (int k = 0; k < 10; k++) begin
      run(5'b00100, 5'b00100, 1'b0, 1'b0, 1);
      chk("disabled", (k >= 5) ? 5'b00100 : 5'b00000, 1'b0, 3'd2, 1'b0, 8'd0, 8'd0);
    end
    // Held button when enable rises yields nothing until re-pressed.
    for (int k = 0; k < 10; k++) begin
      run(5'b00100, 5'b00100, 1'b1, 1'b0, 1);
      chk("enable_held", 5'b00100, 1'b0, 3'd2, 1'b0, 8'd0, 8'd0);
    end
    run(5'b00000, 5'b00100, 1'b1, 1'b0, 8);
    run(5'b00100, 5'b00100, 1'b1, 1'b0, 7);
    chk("repress_hit", 5'b00100, 1'b1, 3'd2, 1'b0, 8'd1, 8'd0);
    run(5'b00000, 5'b00100, 1'b1, 1'b0, 8);

    // Reset mid-debounce: held button needs a full new period afterwards.
    run(5'b00010, 5'b00000, 1'b1, 1'b0, 4);
    reset = 1'b1;
    run(5'b00010, 5'b00000, 1'b1, 1'b0, 1);
    chk("reset_mid", 5'b0, 1'b0, 3'd0, 1'b0, 8'd0, 8'd0);
    reset = 1'b0;
    run(5'b00010, 5'b00000, 1'b1, 1'b0, 5);
    chk("post_reset_wait", 5'b0, 1'b0, 3'd0, 1'b0, 8'd0, 8'd0);
    run(5'b00010, 5'b00000, 1'b1, 1'b0, 1);
    chk("post_reset_stable", 5'b00010, 1'b0, 3'd0, 1'b0, 8'd0, 8'd0);
    run(5'b00010, 5'b00000, 1'b1, 1'b0, 1);
    chk("post_reset_miss", 5'b00010, 1'b0, 3'd0, 1'b1, 8'd0, 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
